// File: rtl/dram_arb_pkg.sv
// dram_arb_pkg: FSM state encoding and default widths for dram_read_arbiter
package dram_arb_pkg;
  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_ISSUE = 3'd1;
  localparam logic [2:0] S_XFER  = 3'd2;
  localparam logic [2:0] S_DONE  = 3'd3;
  localparam logic [2:0] S_ZACK  = 3'd4;
  localparam int DEF_NUM_REQ = 2;
  localparam int DEF_NUM_W   = 32;
  localparam int DEF_ADDR_W  = 32;
  localparam int DEF_DATA_W  = 32;
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin picker, first set request at or above rr_ptr (with wrap)
//   req         in  N    request vector
//   rr_ptr      in  IW   highest-priority index
//   grant_valid out 1    any request set
//   grant_idx   out IW   winning index
module rr_arbiter #(
  parameter int N = 2,
  localparam int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] rr_ptr,
  output logic          grant_valid,
  output logic [IW-1:0] grant_idx
);
  logic [2*N-1:0] dbl;
  logic [N-1:0]   rot;
  always_comb begin
    dbl = {req, req} >> rr_ptr;
    rot = dbl[N-1:0];
    grant_valid = |req;
    grant_idx = '0;
    // Walk downward so the lowest rotated position (closest to rr_ptr) wins.
    for (int k = N - 1; k >= 0; k--)
      if (rot[k]) grant_idx = IW'((int'(rr_ptr) + k) % N);
  end
endmodule

// File: rtl/dram_read_arbiter.sv
// dram_read_arbiter: round-robin sharing of one DRAM burst-read engine between NUM_REQ readers
//   req_kick/req_num/req_addr  in   per-requester burst request (slice i = requester i)
//   req_busy/req_we            out  per-requester busy and return strobe (owner only)
//   req_dout                   out  return data, broadcast, valid with req_we
//   dram_kick/num/addr         out  engine request, latched at grant
//   dram_busy/dout/we          in   engine status and return words
//   owner                      out  current or last grant index
//   err_overrun                out  sticky, stray or excess dram_we
module dram_read_arbiter
  import dram_arb_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ,
  parameter int NUM_W   = DEF_NUM_W,
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int DATA_W  = DEF_DATA_W
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_REQ-1:0]        req_kick,
  input  logic [NUM_REQ*NUM_W-1:0]  req_num,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  output logic [NUM_REQ-1:0]        req_busy,
  output logic [NUM_REQ-1:0]        req_we,
  output logic [DATA_W-1:0]         req_dout,
  output logic                      dram_kick,
  output logic [NUM_W-1:0]          dram_num,
  output logic [ADDR_W-1:0]         dram_addr,
  input  logic                      dram_busy,
  input  logic [DATA_W-1:0]         dram_dout,
  input  logic                      dram_we,
  output logic [$clog2(NUM_REQ)-1:0] owner,
  output logic                      err_overrun
);
  localparam int IW = $clog2(NUM_REQ);
  localparam logic [NUM_REQ-1:0] ONE = NUM_REQ'(1);
  logic [2:0]         state_q, state_d;
  logic [IW-1:0]      owner_q, owner_d, rr_q, rr_d, gidx;
  logic               gvalid;
  logic [NUM_W-1:0]   num_q, num_d, cnt_q, cnt_d, gnum;
  logic [ADDR_W-1:0]  addr_q, addr_d, gaddr;
  logic               kick_q, kick_d, err_q, err_d, accept;
  logic [NUM_REQ-1:0] busy_q, busy_d, we_q, we_d;
  logic [DATA_W-1:0]  dout_q, dout_d;
  rr_arbiter #(.N(NUM_REQ)) u_rr (
    .req         (req_kick),
    .rr_ptr      (rr_q),
    .grant_valid (gvalid),
    .grant_idx   (gidx)
  );
  assign gnum  = req_num[int'(gidx)*NUM_W +: NUM_W];
  assign gaddr = req_addr[int'(gidx)*ADDR_W +: ADDR_W];
  // A return word is only legal while transferring and before the burst is full.
  assign accept = state_q == S_XFER && cnt_q != num_q;
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    rr_d    = rr_q;
    num_d   = num_q;
    addr_d  = addr_q;
    cnt_d   = cnt_q;
    kick_d  = kick_q;
    busy_d  = busy_q;
    we_d    = '0;
    dout_d  = dout_q;
    err_d   = err_q | (dram_we & ~accept);
    case (state_q)
      S_IDLE: if (gvalid && !dram_busy) begin
        owner_d = gidx;
        num_d   = gnum;
        addr_d  = gaddr;
        cnt_d   = '0;
        state_d = gnum == '0 ? S_ZACK : S_ISSUE;
        kick_d  = gnum != '0;
        busy_d  = gnum == '0 ? ONE << gidx : '0;
      end
      S_ISSUE: if (dram_busy) begin
        state_d = S_XFER;
        kick_d  = 1'b0;
        busy_d  = ONE << owner_q;
      end
      S_XFER: begin
        if (dram_we && accept) begin
          cnt_d  = cnt_q + 1'b1;
          we_d   = ONE << owner_q;
          dout_d = dram_dout;
        end
        // Uses the registered count, so a final word arriving with busy falling exits next cycle.
        if (!dram_busy && cnt_q == num_q) begin
          state_d = S_DONE;
          busy_d  = '0;
        end
      end
      S_DONE: begin
        rr_d    = owner_q == IW'(NUM_REQ - 1) ? '0 : owner_q + 1'b1;
        state_d = S_IDLE;
      end
      S_ZACK: begin
        busy_d  = '0;
        state_d = S_DONE;
      end
      default: state_d = S_IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= S_IDLE;
      owner_q <= '0;
      rr_q    <= '0;
      num_q   <= '0;
      addr_q  <= '0;
      cnt_q   <= '0;
      kick_q  <= 1'b0;
      busy_q  <= '0;
      we_q    <= '0;
      dout_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      rr_q    <= rr_d;
      num_q   <= num_d;
      addr_q  <= addr_d;
      cnt_q   <= cnt_d;
      kick_q  <= kick_d;
      busy_q  <= busy_d;
      we_q    <= we_d;
      dout_q  <= dout_d;
      err_q   <= err_d;
    end
  assign req_busy    = busy_q;
  assign req_we      = we_q;
  assign req_dout    = dout_q;
  assign dram_kick   = kick_q;
  assign dram_num    = num_q;
  assign dram_addr   = addr_q;
  assign owner       = owner_q;
  assign err_overrun = err_q;
endmodule

// File: tb/tb_dram_read_arbiter.sv
// tb_dram_read_arbiter: directed bench with a per-cycle reference model of the arbiter
module tb_dram_read_arbiter;
  localparam int N = 2;
  logic clk = 1'b0, rst_n = 1'b1;
  logic [N-1:0] req_kick, req_busy, req_we;
  logic [N*32-1:0] req_num, req_addr;
  logic [31:0] req_dout, dram_num, dram_addr, dram_dout;
  logic dram_kick, dram_busy, dram_we, err_overrun;
  logic [0:0] owner;
  int n_cmp = 0, n_bad = 0;
  int c0 = 0, c1 = 0, ck = 0;
  always #5 clk = ~clk;
  dram_read_arbiter #(.NUM_REQ(N), .NUM_W(32), .ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .req_kick(req_kick), .req_num(req_num), .req_addr(req_addr),
    .req_busy(req_busy), .req_we(req_we), .req_dout(req_dout), .dram_kick(dram_kick),
    .dram_num(dram_num), .dram_addr(dram_addr), .dram_busy(dram_busy), .dram_dout(dram_dout),
    .dram_we(dram_we), .owner(owner), .err_overrun(err_overrun)
  );
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h required %h at %0t", nm, act, exp, $time);
    end
  endtask
  // Reference model: phase 0 idle, 1 engine kicked, 2 transferring, 3 done gap, 4 zero-length ack.
  int m_phase = 0, m_own = 0, m_ptr = 0;
  logic [31:0] m_num = 0, m_addr = 0, m_got = 0, m_dout = 0;
  logic [N-1:0] m_we = 0;
  logic m_err = 0, m_acc, m_found;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_phase = 0; m_own = 0; m_ptr = 0; m_num = 0; m_addr = 0; m_got = 0;
      m_dout = 0; m_we = 0; m_err = 0;
    end else begin
      m_acc = m_phase == 2 && m_got != m_num;
      if (dram_we && !m_acc) m_err = 1'b1;
      m_we = 0;
      case (m_phase)
        0: if (req_kick != 0 && !dram_busy) begin
          m_found = 1'b0;
          for (int k = 0; k < N; k++) begin
            int idx;
            idx = (m_ptr + k) % N;
            if (!m_found && req_kick[idx]) begin
              m_found = 1'b1;
              m_own = idx;
            end
          end
          m_num = req_num[m_own*32 +: 32];
          m_addr = req_addr[m_own*32 +: 32];
          m_got = 0;
          m_phase = m_num == 0 ? 4 : 1;
        end
        1: if (dram_busy) m_phase = 2;
        2: begin
          if (!dram_busy && m_got == m_num) m_phase = 3;
          if (dram_we && m_acc) begin
            m_got = m_got + 1;
            m_we[m_own] = 1'b1;
            m_dout = dram_dout;
          end
        end
        3: begin m_ptr = (m_own + 1) % N; m_phase = 0; end
        default: m_phase = 3;
      endcase
    end
  end
  always @(negedge clk) begin
    chk("dram_kick", dram_kick, m_phase == 1);
    chk("dram_num", dram_num, m_num);
    chk("dram_addr", dram_addr, m_addr);
    chk("owner", owner, 64'(m_own));
    chk("req_busy", req_busy, (m_phase == 2 || m_phase == 4) ? 64'(1 << m_own) : 64'd0);
    chk("req_we", req_we, m_we);
    chk("req_dout", req_dout, m_dout);
    chk("err_overrun", err_overrun, m_err);
    if (req_we[0]) c0++;
    if (req_we[1]) c1++;
    if (dram_kick) ck++;
  end
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic set_req(input int i, input logic [31:0] n, input logic [31:0] a);
    req_num[i*32 +: 32] = n;
    req_addr[i*32 +: 32] = a;
  endtask
  task automatic engine(input int words, output int who);
    int t;
    t = 0;
    while (dram_kick !== 1'b1 && t < 100) begin tick(); t++; end
    if (dram_kick !== 1'b1) begin
      n_cmp++; n_bad++;
      $display("FAIL engine_kick: dram_kick=%b required 1 within 100 cycles", dram_kick);
      who = -1;
      return;
    end
    who = int'(owner);
    dram_busy = 1'b1;
    tick();
    req_kick[who] = 1'b0;
    for (int w = 0; w < words; w++) begin
      dram_we = 1'b1;
      dram_dout = $urandom;
      tick();
    end
    dram_we = 1'b0;
    dram_busy = 1'b0;
    tick();
    tick();
  endtask
  initial begin
    int who, s0, s1, sk;
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end
  initial begin
    int who, s0, s1, sk;
    req_kick = 0; req_num = 0; req_addr = 0;
    dram_busy = 0; dram_we = 0; dram_dout = 0;
    #1 rst_n = 1'b0;
    #2;
    chk("reset_ctl", {dram_kick, req_busy, req_we, err_overrun, owner}, 64'd0);
    chk("reset_data", {dram_num, dram_addr}, 64'd0);
    #9 rst_n = 1'b1;
    tick();
    // single burst
    set_req(0, 64, 32'h0100_0000);
    req_kick = 2'b01;
    tick();
    chk("t1_kick_latency", dram_kick, 1);
    chk("t1_addr", dram_addr, 32'h0100_0000);
    s0 = c0; s1 = c1;
    engine(64, who);
    chk("t1_owner", who, 0);
    chk("t1_we0_count", c0 - s0, 64);
    chk("t1_we1_count", c1 - s1, 0);
    // contention from a fresh round-robin pointer
    #2 rst_n = 1'b0;
    #4 rst_n = 1'b1;
    tick();
    set_req(0, 64, 32'h0000_1000);
    set_req(1, 64, 32'h0000_2000);
    req_kick = 2'b11;
    for (int b = 0; b < 4; b++) begin
      engine(64, who);
      chk("t2_grant_order", who, b % 2);
      if (who >= 0) req_kick[who] = 1'b1;
    end
    req_kick = 0;
    tick();
    // zero-length request
    sk = ck;
    set_req(1, 0, 32'h0000_3000);
    req_kick = 2'b10;
    tick();
    chk("t3_busy_on", req_busy, 2'b10);
    req_kick = 0;
    tick();
    chk("t3_busy_off", req_busy, 2'b00);
    tick();
    chk("t3_no_dram_kick", ck - sk, 0);
    // overrun
    s0 = c0;
    set_req(0, 4, 32'h0000_4000);
    req_kick = 2'b01;
    engine(5, who);
    chk("t4_owner", who, 0);
    chk("t4_we0_count", c0 - s0, 4);
    chk("t4_err_set", err_overrun, 1);
    repeat (3) tick();
    chk("t4_err_held", err_overrun, 1);
    // reset in the middle of a transfer
    set_req(0, 64, 32'h0000_5000);
    req_kick = 2'b01;
    tick();
    dram_busy = 1'b1;
    tick();
    req_kick = 0;
    for (int w = 0; w < 10; w++) begin
      dram_we = 1'b1;
      dram_dout = $urandom;
      tick();
    end
    dram_we = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("t5_reset_ctl", {dram_kick, req_busy, req_we, err_overrun, owner}, 64'd0);
    chk("t5_reset_data", {dram_num, dram_addr}, 64'd0);
    chk("t5_reset_dout", req_dout, 0);
    dram_busy = 1'b0;
    @(negedge clk);
    #2 rst_n = 1'b1;
    tick();
    s1 = c1;
    set_req(1, 8, 32'h0000_6000);
    req_kick = 2'b10;
    tick();
    chk("t5_regrant_kick", dram_kick, 1);
    chk("t5_regrant_owner", owner, 1);
    engine(8, who);
    chk("t5_we1_count", c1 - s1, 8);
    // engine busy blocks arbitration
    s0 = c0;
    dram_busy = 1'b1;
    set_req(0, 4, 32'h0000_7000);
    req_kick = 2'b01;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t6_blocked", dram_kick, 0);
    end
    dram_busy = 1'b0;
    tick();
    chk("t6_grant_kick", dram_kick, 1);
    chk("t6_grant_owner", owner, 0);
    engine(4, who);
    chk("t6_we0_count", c0 - s0, 4);
    repeat (2) tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
